// File: rtl/regfile_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_pkg
// Description : Shared types and default sizes for the register-bank write
//               scheduler (state encoding, default parameter values).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_pkg;

  // Scheduler states: arbitrate requesters, or sweep the bank to zero
  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_CLR = 1'b1
  } state_t;

  localparam int N_DEF    = 32;
  localparam int BITS_DEF = 64;
  localparam int NREQ_DEF = 2;

endpackage : regfile_wr_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request found searching upward from rr_ptr, modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int RW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic [RW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant
);

  int   w_idx;
  logic w_found;

  // Rotating priority search; at most one grant bit is ever set
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      w_idx = (int'(rr_ptr) + off) % N_REQ;
      if (en && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_scheduler
// Description : Shares the single write port of an N x BITS register bank
//               among N_REQ requesters (round-robin, valid/ready), through a
//               one-stage write buffer. Includes a clear sweep sequencer.
//               Optional macro WR_BYPASS_EN adds two write-to-read bypass
//               ports for same-cycle forwarding of the pending write.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_scheduler
  import regfile_wr_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int BITS  = BITS_DEF,
  parameter int N_REQ = NREQ_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][$clog2(N)-1:0]  req_ptr,
  input  logic [N_REQ-1:0][BITS-1:0]       req_data,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic                             stall,
  input  logic                             clr_start,
  output logic                             clr_done,
  output logic                             busy,
  output logic                             wr_en,
  output logic [$clog2(N)-1:0]             ptr_wr,
  output logic [BITS-1:0]                  data_wr
`ifdef WR_BYPASS_EN
  ,
  input  logic [$clog2(N)-1:0]             ptr_rd_1,
  input  logic [$clog2(N)-1:0]             ptr_rd_2,
  input  logic [BITS-1:0]                  bank_rd_1,
  input  logic [BITS-1:0]                  bank_rd_2,
  output logic [BITS-1:0]                  data_rd_1,
  output logic [BITS-1:0]                  data_rd_2
`endif
);

  localparam int PW = $clog2(N);
  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] c_last_ptr = PW'(N - 1);

  typedef struct packed {
    logic [PW-1:0]   ptr;
    logic [BITS-1:0] data;
  } wr_req_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [PW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_buf_vld, w_buf_vld_nxt;
  wr_req_t         r_buf, w_buf_nxt;
  logic            r_clr_done, w_clr_done_nxt;
  logic            w_arb_en;
  logic [N_REQ-1:0] w_grant;

  // A clear request pre-empts any grant in the same cycle
  assign w_arb_en = (r_state == ST_ARB) && !stall && !clr_start;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .RW    (RW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .en     (w_arb_en),
    .rr_ptr (r_rr_ptr),
    .grant  (w_grant)
  );

  assign req_ready = w_grant;
  assign busy      = (r_state == ST_CLR);
  assign clr_done  = r_clr_done;
  assign ptr_wr    = r_buf.ptr;
  assign data_wr   = r_buf.data;
  // Register 0 is hard-wired: its writes are accepted but never reach the bank
  assign wr_en     = r_buf_vld && (r_buf.ptr != '0);

  // Next-state, buffer load and round-robin pointer update
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr_ptr;
    w_cnt_nxt      = r_cnt;
    w_buf_vld_nxt  = 1'b0;
    w_buf_nxt      = r_buf;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (clr_start) begin
          w_state_nxt = ST_CLR;
          w_cnt_nxt   = PW'(1);
        end else begin
          for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
              w_buf_vld_nxt  = 1'b1;
              w_buf_nxt.ptr  = req_ptr[i];
              w_buf_nxt.data = req_data[i];
              w_rr_nxt       = RW'((i + 1) % N_REQ);
            end
          end
        end
      end
      ST_CLR: begin
        w_buf_vld_nxt  = 1'b1;
        w_buf_nxt.ptr  = r_cnt;
        w_buf_nxt.data = '0;
        w_cnt_nxt      = r_cnt + PW'(1);
        if (r_cnt == c_last_ptr) begin
          w_state_nxt    = ST_ARB;
          w_clr_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // State, pointer and write-buffer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_buf_vld  <= 1'b0;
      r_buf      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_buf_vld  <= w_buf_vld_nxt;
      r_buf      <= w_buf_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

`ifdef WR_BYPASS_EN
  // Forward the in-flight write to readers of the same register
  assign data_rd_1 = (wr_en && (ptr_wr == ptr_rd_1)) ? data_wr : bank_rd_1;
  assign data_rd_2 = (wr_en && (ptr_wr == ptr_rd_2)) ? data_wr : bank_rd_2;
`endif

endmodule : regfile_wr_scheduler
`default_nettype wire

// File: tb/tb_regfile_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_scheduler
// Description : Self-checking bench for regfile_wr_scheduler with a write
//               scoreboard and a behavioural register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_scheduler;

  localparam int N     = 32;
  localparam int BITS  = 64;
  localparam int N_REQ = 2;
  localparam int PW    = 5;

  logic clk = 1'b0;
  logic rst;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0][PW-1:0]   req_ptr;
  logic [N_REQ-1:0][BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic stall, clr_start, clr_done, busy, wr_en;
  logic [PW-1:0]   ptr_wr;
  logic [BITS-1:0] data_wr;
`ifdef WR_BYPASS_EN
  logic [PW-1:0]   ptr_rd_1, ptr_rd_2;
  logic [BITS-1:0] bank_rd_1, bank_rd_2, data_rd_1, data_rd_2;
`endif

  logic [BITS-1:0] bank [N];

  typedef struct packed {
    logic [PW-1:0]   ptr;
    logic [BITS-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   exp_rr = 0;

  regfile_wr_scheduler #(.N(N), .BITS(BITS), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ptr   (req_ptr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .busy      (busy),
    .wr_en     (wr_en),
    .ptr_wr    (ptr_wr),
    .data_wr   (data_wr)
`ifdef WR_BYPASS_EN
    ,
    .ptr_rd_1  (ptr_rd_1),
    .ptr_rd_2  (ptr_rd_2),
    .bank_rd_1 (bank_rd_1),
    .bank_rd_2 (bank_rd_2),
    .data_rd_1 (data_rd_1),
    .data_rd_2 (data_rd_2)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural register bank; cleared while reset is held
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < N; i++) bank[i] <= '0;
    end else if (wr_en === 1'b1) begin
      bank[ptr_wr] <= data_wr;
    end
  end

`ifdef WR_BYPASS_EN
  assign bank_rd_1 = bank[ptr_rd_1];
  assign bank_rd_2 = bank[ptr_rd_2];
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] v);
    for (int off = 0; off < N_REQ; off++) begin
      if (v[(exp_rr + off) % N_REQ]) return (exp_rr + off) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int g);
    logic [N_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // One-cycle write request from requester r; returns in the buffered cycle
  task automatic issue(input int r, input logic [PW-1:0] p, input logic [BITS-1:0] d);
    int g;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_ptr[r]   = p;
    req_data[r]  = d;
    #1;
    g = pick(req_valid);
    chk("issue_ready", req_ready, onehot(g));
    if (p != '0) sb_q.push_back({p, d});
    exp_rr = (g + 1) % N_REQ;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Monitor: every bank write must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got ptr %0d data 0x%0h, required no write", ptr_wr, data_wr);
        end else begin
          e = sb_q.pop_front();
          chk("wr_ptr", ptr_wr, e.ptr);
          chk("wr_data", data_wr, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int seq_a[4];
    int g;
    int busy_cnt, done_cnt, nz;
    seq_a = '{1, 0, 1, 0};
    rst = 1'b0; req_valid = '0; req_ptr = '0; req_data = '0;
    stall = 1'b0; clr_start = 1'b0;
`ifdef WR_BYPASS_EN
    ptr_rd_1 = '0; ptr_rd_2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_rr = 0;
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_ptr_wr", ptr_wr, 0);
    chk("rst_data_wr", data_wr, 0);
    @(posedge clk); #1;

    // Single write
    issue(0, 5'd5, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("bank5", bank[5], 64'hDEAD_BEEF);

    // Contention: rr pointer sits at 1 after the single write
    req_ptr[0] = 5'd3; req_data[0] = 64'h33;
    req_ptr[1] = 5'd4; req_data[1] = 64'h44;
    req_valid  = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      g = pick(req_valid);
      chk("contend_order", g, seq_a[c]);
      chk("contend_ready", req_ready, onehot(seq_a[c]));
      sb_q.push_back({req_ptr[seq_a[c]], req_data[seq_a[c]]});
      exp_rr = (seq_a[c] + 1) % N_REQ;
      @(posedge clk); #1;
    end
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stall_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("resume_ready", req_ready, onehot(seq_a[c]));
      sb_q.push_back({req_ptr[seq_a[c]], req_data[seq_a[c]]});
      exp_rr = (seq_a[c] + 1) % N_REQ;
      @(posedge clk); #1;
    end
    req_valid = '0;

    // Register 0 write is accepted and discarded
    issue(0, 5'd0, 64'h7);
    @(negedge clk);
    chk("reg0_wr_en", wr_en, 0);
    @(posedge clk); #1;
    chk("reg0_bank", bank[0], 0);

    // Preload registers 1..31
    for (int i = 1; i < N; i++) issue(i % 2, PW'(i), 64'h1000 + 64'(i));
    repeat (2) @(posedge clk);
    #1;

    // Clear sweep, with stall raised (must be ignored) and a pending request
    for (int i = 1; i < N; i++) sb_q.push_back({PW'(i), 64'h0});
    clr_start = 1'b1;
    req_ptr[0] = '0; req_data[0] = '0; req_valid = 2'b01;
    #1;
    chk("clr_start_ready", req_ready, 0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    stall = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        chk("clr_ready", req_ready, 0);
      end
      if (clr_done === 1'b1) done_cnt++;
    end
    chk("clr_busy_cycles", busy_cnt, 31);
    chk("clr_done_pulses", done_cnt, 1);
    req_valid = '0; stall = 1'b0;
    @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (bank[i] != '0) nz++;
    chk("clr_nonzero_regs", nz, 0);

    // Sweep aborted by reset at its tenth edge: writes 1..9 only, no done
    for (int i = 1; i <= 9; i++) sb_q.push_back({PW'(i), 64'h0});
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rr = 0;
    busy_cnt = 0; done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
    end
    chk("abort_done_pulses", done_cnt, 0);
    chk("abort_busy_cycles", busy_cnt, 0);
    @(posedge clk); #1;
    issue(1, 5'd12, 64'hABC);

`ifdef WR_BYPASS_EN
    issue(0, 5'd9, 64'h55);
    ptr_rd_1 = 5'd9;
    ptr_rd_2 = 5'd3;
    #1;
    chk("bypass_wr_en", wr_en, 1);
    chk("bypass_rd_1", data_rd_1, 64'h55);
    chk("bypass_rd_2", data_rd_2, 64'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_wr_scheduler
`default_nettype wire
